// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit: funct3 decode, lane steering, extension, fault detect
// Optional MAU_TIMEOUT_EN: REQ-state wait counter that faults after TIMEOUT_CYCLES without mem_ack.
module mem_access_unit #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_func,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t      state, state_nx;
  logic [2:0]  func_q;
  logic [1:0]  off_q;
  logic        illegal, misaligned, fault;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic        timeout_hit;

  // Request decode, evaluated on the raw core inputs while IDLE.
  always_comb begin
    illegal    = req_we ? (req_func[2] || req_func[1:0] == 2'b11)
                        : (req_func == 3'b011 || req_func[2:1] == 2'b11);
    misaligned = (req_func[1:0] == 2'b01 && req_addr[0]) ||
                 (req_func[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    fault      = illegal || misaligned;
    be_d       = 4'b1111;
    wdata_d    = req_wdata;
    if (req_we) begin
      case (req_func[1:0])
        2'b00: begin
          be_d    = 4'b0001 << req_addr[1:0];
          wdata_d = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          be_d    = 4'b0011 << req_addr[1:0];
          wdata_d = {2{req_wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Load lane select and extension from the latched funct3/offset.
  always_comb begin
    ld_byte = mem_rdata[{off_q, 3'b000} +: 8];
    ld_half = mem_rdata[{off_q[1], 4'b0000} +: 16];
    case (func_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

`ifdef MAU_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_cnt;

  // An ack in the final cycle takes priority over the timeout.
  assign timeout_hit = (state == REQ) && !mem_ack && (wait_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || state != REQ) wait_cnt <= '0;
    else                        wait_cnt <= wait_cnt + 16'd1;
  end
`else
  logic unused_timeout_cfg;
  assign timeout_hit        = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_req    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = rst_n;
        if (req_valid) state_nx = fault ? RESP : REQ;
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem_ack || timeout_hit) state_nx = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      func_q     <= '0;
      off_q      <= '0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            func_q     <= req_func;
            off_q      <= req_addr[1:0];
            resp_err   <= fault;
            resp_rdata <= '0;
            // Faulted requests leave the memory bus untouched.
            if (!fault) begin
              mem_we    <= req_we;
              mem_be    <= be_d;
              mem_addr  <= req_addr[ADDR_W-1:2];
              mem_wdata <= wdata_d;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            resp_rdata <= mem_we ? 32'h0 : ld_ext;
            resp_err   <= 1'b0;
          end else if (timeout_hit) begin
            resp_rdata <= 32'h0;
            resp_err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
